// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one UART transmitter among
// NUM_REQ byte producers. One byte is granted at a time, and the next grant
// waits for the frame to finish. The block also owns the transmitter's
// baud_select, and a new rate is applied only between frames.
//
// Optional build macro UART_TX_ARB_TIMEOUT_EN adds a 16-clock watchdog on the
// wait for tx_busy, together with the tx_timeout output.
//
// Handshake: a requester holds req_valid and req_data stable until it sees
// its req_ready bit pulse for one cycle, which means the byte has been taken.
// Toward the transmitter, tx_wr is a one-cycle start pulse with tx_data
// valid. tx_busy high marks a frame in flight. Its falling edge ends the frame.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int REQ_IDX_W = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic                   cfg_wr,
    input  logic [2:0]             cfg_baud_select,
    output logic [2:0]             baud_select,
    output logic [7:0]             tx_data,
    output logic                   tx_wr,
    input  logic                   tx_busy,
    output logic [REQ_IDX_W-1:0]   grant_idx,
    output logic                   active,
`ifdef UART_TX_ARB_TIMEOUT_EN
    output logic                   tx_timeout,
`endif
    output logic [1:0]             dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t                 r_state, w_state;
    logic [NUM_REQ-1:0]     r_req_ready, w_req_ready;
    logic [7:0]             r_tx_data, w_tx_data;
    logic                   r_tx_wr, w_tx_wr;
    logic [2:0]             r_baud, w_baud;
    logic [REQ_IDX_W-1:0]   r_grant_idx, w_grant_idx;
    logic                   r_active, w_active;
    logic [REQ_IDX_W-1:0]   r_last_grant, w_last_grant;
    logic                   r_cfg_pending, w_cfg_pending;
    logic [2:0]             r_cfg_val, w_cfg_val;
    logic                   w_found;
    logic [REQ_IDX_W-1:0]   w_pick;
    logic [REQ_IDX_W-1:0]   w_cand;
`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [3:0]             r_wdog, w_wdog;
    logic                   r_tx_timeout, w_tx_timeout;
`endif

    // Round-robin search: first valid requester after last_grant, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = REQ_IDX_W'((int'(r_last_grant) + k) % NUM_REQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    // Next-state and next-output logic. All outputs come from registers.
    always_comb begin
        w_state       = r_state;
        w_req_ready   = '0;
        w_tx_wr       = 1'b0;
        w_tx_data     = r_tx_data;
        w_baud        = r_baud;
        w_grant_idx   = r_grant_idx;
        w_active      = r_active;
        w_last_grant  = r_last_grant;
        w_cfg_pending = r_cfg_pending;
        w_cfg_val     = r_cfg_val;
`ifdef UART_TX_ARB_TIMEOUT_EN
        w_wdog        = r_wdog;
        w_tx_timeout  = 1'b0;
`endif
        // A rate change during a frame is parked here. The last write wins.
        if (r_state != S_IDLE && cfg_wr) begin
            w_cfg_pending = 1'b1;
            w_cfg_val     = cfg_baud_select;
        end
        case (r_state)
            S_IDLE: begin
                if (r_cfg_pending || cfg_wr) begin
                    w_baud        = cfg_wr ? cfg_baud_select : r_cfg_val;
                    w_cfg_pending = 1'b0;
                end else if (w_found && !tx_busy) begin
                    w_req_ready[w_pick] = 1'b1;
                    w_tx_data           = req_data[{w_pick, 3'b000} +: 8];
                    w_grant_idx         = w_pick;
                    w_last_grant        = w_pick;
                    w_active            = 1'b1;
                    w_state             = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_tx_wr = 1'b1;
                w_state = S_WAIT_BUSY;
`ifdef UART_TX_ARB_TIMEOUT_EN
                w_wdog  = '0;
`endif
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    w_state = S_WAIT_DONE;
`ifdef UART_TX_ARB_TIMEOUT_EN
                end else if (r_wdog == 4'hF) begin
                    w_tx_timeout = 1'b1;
                    w_active     = 1'b0;
                    w_state      = S_IDLE;
                end else begin
                    w_wdog = r_wdog + 4'd1;
`endif
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    w_active = 1'b0;
                    w_state  = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    // State and output registers. Reset aborts any frame immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_req_ready   <= '0;
            r_tx_data     <= '0;
            r_tx_wr       <= 1'b0;
            r_baud        <= 3'b000;
            r_grant_idx   <= '0;
            r_active      <= 1'b0;
            r_last_grant  <= REQ_IDX_W'(NUM_REQ - 1);
            r_cfg_pending <= 1'b0;
            r_cfg_val     <= 3'b000;
`ifdef UART_TX_ARB_TIMEOUT_EN
            r_wdog        <= '0;
            r_tx_timeout  <= 1'b0;
`endif
        end else begin
            r_state       <= w_state;
            r_req_ready   <= w_req_ready;
            r_tx_data     <= w_tx_data;
            r_tx_wr       <= w_tx_wr;
            r_baud        <= w_baud;
            r_grant_idx   <= w_grant_idx;
            r_active      <= w_active;
            r_last_grant  <= w_last_grant;
            r_cfg_pending <= w_cfg_pending;
            r_cfg_val     <= w_cfg_val;
`ifdef UART_TX_ARB_TIMEOUT_EN
            r_wdog        <= w_wdog;
            r_tx_timeout  <= w_tx_timeout;
`endif
        end
    end

    assign req_ready   = r_req_ready;
    assign tx_data     = r_tx_data;
    assign tx_wr       = r_tx_wr;
    assign baud_select = r_baud;
    assign grant_idx   = r_grant_idx;
    assign active      = r_active;
    assign dbg_state   = r_state;
`ifdef UART_TX_ARB_TIMEOUT_EN
    assign tx_timeout  = r_tx_timeout;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=4). The transmitter model
// raises tx_busy for frame_len clocks after each tx_wr.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        cfg_wr;
    logic [2:0]  cfg_baud_select;
    logic [2:0]  baud_select;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy;
    logic [1:0]  grant_idx;
    logic        active;
    logic [1:0]  dbg_state;
`ifdef UART_TX_ARB_TIMEOUT_EN
    logic        tx_timeout;
`endif

    int n_total = 0;
    int n_bad   = 0;

    // transmitter model and monitor history
    int          tm_cnt    = 0;
    logic        tm_en     = 1'b1;
    int          frame_len = 5;
    logic        prev_active = 1'b0;
    logic [2:0]  prev_baud   = 3'b000;
    logic [1:0]  last_g      = 2'd0;

    // scoreboard of expected grant indices
    logic [1:0]  exp_q[$];

    uart_tx_arbiter #(.NUM_REQ(4), .REQ_IDX_W(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .cfg_wr          (cfg_wr),
        .cfg_baud_select (cfg_baud_select),
        .baud_select     (baud_select),
        .tx_data         (tx_data),
        .tx_wr           (tx_wr),
        .tx_busy         (tx_busy),
        .grant_idx       (grant_idx),
        .active          (active),
`ifdef UART_TX_ARB_TIMEOUT_EN
        .tx_timeout      (tx_timeout),
`endif
        .dbg_state       (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // global time limit
    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] idx_of(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
        return r;
    endfunction

    // One clock: sample after the edge, run monitors, advance the transmitter model.
    task automatic tick();
        @(posedge clk);
        #1;
        if (req_ready != 4'b0000) check("ready_onehot", $countones(req_ready), 1);
        if (prev_active && active) check("baud_hold", baud_select, prev_baud);
        if (tx_wr) check("tx_wr_no_overlap", tm_cnt, 0);
        if (tm_cnt > 0) tm_cnt--;
        if (tx_wr && tm_en) tm_cnt = frame_len;
        tx_busy     = (tm_cnt > 0);
        prev_active = active;
        prev_baud   = baud_select;
    endtask

    task automatic apply_reset();
        reset           = 1'b1;
        req_valid       = 4'b0000;
        req_data        = {8'h13, 8'h12, 8'h11, 8'h10};
        cfg_wr          = 1'b0;
        cfg_baud_select = 3'b000;
        tm_cnt          = 0;
        tx_busy         = 1'b0;
        prev_active     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((active || tx_busy) && n < 200) begin
            tick();
            n++;
        end
        check("idle_reached", active, 1'b0);
    endtask

    // Hold req_valid until n frames have been issued, checking grants against exp_q.
    task automatic run_grants(input logic [3:0] valid, input int n);
        int wr = 0;
        int t  = 0;
        logic [1:0] g;
        logic [1:0] e;
        req_valid = valid;
        while (wr < n && t < 400) begin
            tick();
            t++;
            if (req_ready != 4'b0000) begin
                g = idx_of(req_ready);
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
                check("grant_order", g, e);
                check("grant_idx", grant_idx, g);
                last_g = g;
            end
            if (tx_wr) begin
                wr++;
                check("tx_data", tx_data, 8'h10 + last_g);
            end
        end
        check("frames_issued", wr, n);
        req_valid = 4'b0000;
        wait_idle();
        check("exp_q_empty", exp_q.size(), 0);
    endtask

    initial begin
        apply_reset();
        // reset state
        check("rst_req_ready", req_ready, 4'b0000);
        check("rst_tx_wr", tx_wr, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_baud", baud_select, 3'b000);
        check("rst_grant_idx", grant_idx, 2'd0);
        check("rst_active", active, 1'b0);
        check("rst_state", dbg_state, 2'd0);

        // single request from 2, 20-clock frame
        frame_len = 20;
        req_data[23:16] = 8'hA5;
        req_valid = 4'b0100;
        tick();
        check("t1_ready", req_ready, 4'b0100);
        check("t1_grant_idx", grant_idx, 2'd2);
        check("t1_active", active, 1'b1);
        check("t1_no_wr_yet", tx_wr, 1'b0);
        req_valid = 4'b0000;
        tick();
        check("t1_ready_pulse", req_ready, 4'b0000);
        check("t1_tx_wr", tx_wr, 1'b1);
        check("t1_tx_data", tx_data, 8'hA5);
        tick();
        check("t1_wr_pulse", tx_wr, 1'b0);
        for (int n = 0; n < 40 && tx_busy; n++) tick();
        check("t1_busy_fell", tx_busy, 1'b0);
        check("t1_active_held", active, 1'b1);
        tick();
        check("t1_active_fell", active, 1'b0);
        check("t1_data_held", tx_data, 8'hA5);
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};

        // all four continuously requesting after reset
        frame_len = 5;
        apply_reset();
        exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
        exp_q.push_back(2'd3); exp_q.push_back(2'd0);
        run_grants(4'b1111, 5);

        // last_grant=1 set up, then 1 and 3 valid: 3 wins, then 1
        exp_q.push_back(2'd1);
        run_grants(4'b0010, 1);
        exp_q.push_back(2'd3); exp_q.push_back(2'd1);
        run_grants(4'b1010, 2);

        // foreign tx_busy in IDLE blocks the grant
        tm_cnt  = 3;
        tx_busy = 1'b1;
        req_valid = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fb_no_grant", req_ready, 4'b0000);
        end
        tick();
        check("fb_grant", req_ready, 4'b0001);
        req_valid = 4'b0000;
        wait_idle();

        // baud change mid-frame is deferred; last write wins
        frame_len = 20;
        cfg_wr = 1'b1; cfg_baud_select = 3'b010;
        tick();
        cfg_wr = 1'b0;
        check("t4_idle_apply", baud_select, 3'b010);
        req_valid = 4'b0101;
        tick();
        check("t4_first_grant", req_ready, 4'b0100);
        req_valid = 4'b0001;
        tick();
        check("t4_tx_wr", tx_wr, 1'b1);
        check("t4_tx_data", tx_data, 8'h12);
        tick();
        tick();
        cfg_wr = 1'b1; cfg_baud_select = 3'b111;
        tick();
        cfg_wr = 1'b0;
        check("t4_hold_a", baud_select, 3'b010);
        tick();
        cfg_wr = 1'b1; cfg_baud_select = 3'b101;
        tick();
        cfg_wr = 1'b0;
        check("t4_hold_b", baud_select, 3'b010);
        for (int n = 0; n < 40 && tx_busy; n++) tick();
        check("t4_busy_fell", tx_busy, 1'b0);
        tick();
        check("t4_active_fell", active, 1'b0);
        check("t4_baud_old", baud_select, 3'b010);
        tick();
        check("t4_baud_new", baud_select, 3'b101);
        check("t4_cfg_cycle_no_grant", req_ready, 4'b0000);
        tick();
        check("t4_next_grant", req_ready, 4'b0001);
        req_valid = 4'b0000;
        wait_idle();

        // reset asserted in WAIT_BUSY
        frame_len = 5;
        tm_en = 1'b0;
        req_valid = 4'b1111;
        tick();
        tick();
        tick();
        check("t5_in_wait_busy", dbg_state, 2'd2);
        #2;
        reset = 1'b1;
        #1;
        check("t5_rst_ready", req_ready, 4'b0000);
        check("t5_rst_tx_wr", tx_wr, 1'b0);
        check("t5_rst_tx_data", tx_data, 8'h00);
        check("t5_rst_baud", baud_select, 3'b000);
        check("t5_rst_grant_idx", grant_idx, 2'd0);
        check("t5_rst_active", active, 1'b0);
        check("t5_rst_state", dbg_state, 2'd0);
        tm_cnt = 0; tx_busy = 1'b0; prev_active = 1'b0; tm_en = 1'b1;
        #2;
        reset = 1'b0;
        tick();
        check("t5_first_grant", req_ready, 4'b0001);
        check("t5_grant_idx", grant_idx, 2'd0);
        req_valid = 4'b0000;
        wait_idle();

`ifdef UART_TX_ARB_TIMEOUT_EN
        // watchdog with tx_busy tied low
        begin
            logic early;
            early = 1'b0;
            tm_en = 1'b0;
            req_valid = 4'b0100;
            tick();
            check("t6_grant", req_ready, 4'b0100);
            req_valid = 4'b0000;
            tick();
            check("t6_tx_wr", tx_wr, 1'b1);
            for (int k = 1; k < 16; k++) begin
                tick();
                early = early | tx_timeout;
            end
            check("t6_no_early_timeout", early, 1'b0);
            check("t6_active_before", active, 1'b1);
            tick();
            check("t6_timeout", tx_timeout, 1'b1);
            check("t6_active_after", active, 1'b0);
            tick();
            check("t6_timeout_pulse", tx_timeout, 1'b0);
            tm_en = 1'b1;
            exp_q.push_back(2'd3);
            run_grants(4'b1001, 1);
        end
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
